// File: rtl/team_06_echo_pkg.sv
// Shared types and helpers for the team_06 single-tap echo effect.
package team_06_echo_pkg;

    // FSM encoding for one sample period: read request, optional wait, mix.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_MIX    = 2'd3
    } echo_state_e;

    // Offset-binary midpoint; the silent output level.
    localparam logic [7:0] SILENCE = 8'd128;

    // Signed 9-bit + 9-bit add, clamped to the signed 8-bit range.
    function automatic logic signed [7:0] sat_add(input logic signed [8:0] x,
                                                  input logic signed [8:0] y);
        logic signed [9:0] sum;
        sum = {x[8], x} + {y[8], y};
        if (sum > 10'sd127)
            return 8'h7f;
        else if (sum < -10'sd128)
            return 8'h80;
        else
            return sum[7:0];
    endfunction

endpackage

// File: rtl/team_06_echo_mixer.sv
// Combinational echo mixer: s = sat(a + (p >>> ECHO_SHIFT)), or a when disabled.
module team_06_echo_mixer
    import team_06_echo_pkg::*;
#(
    parameter int ECHO_SHIFT = 1
) (
    input  logic signed [8:0] a,
    input  logic signed [8:0] p,
    input  logic              enable,
    output logic signed [7:0] s
);

    logic signed [8:0] e;

    // Arithmetic shift keeps negative echoes negative (floor toward -inf).
    assign e = p >>> ECHO_SHIFT;

    // Dry input already fits 8 bits signed; wet path saturates.
    always_comb begin
        s = a[7:0];
        if (enable)
            s = sat_add(a, e);
    end

endmodule

// File: rtl/team_06_echo_effect.sv
// Single-tap feedback echo: per sample period, request the delayed sample,
// mix a scaled copy into the current input, and register the result both to
// the output and to the write-back port of the external delay buffer.
//
// Buffer read handshake: search is a one-cycle request for location offset;
// there is no ready/stall. past_output must hold the requested sample exactly
// READ_LAT cycles after the search cycle, when it is captured in MIX.
module team_06_echo_effect
    import team_06_echo_pkg::*;
#(
    parameter int DEPTH      = 8000,
    parameter int SAMPLE_DIV = 16,
    parameter int READ_LAT   = 1,
    parameter int ECHO_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  audio_in,
    input  logic        echo_enable,
    input  logic [7:0]  past_output,
    output logic [12:0] offset,
    output logic        search,
    output logic [7:0]  echo_out,
    output logic [7:0]  save_audio,
    output logic [1:0]  state_dbg
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WW = $clog2(READ_LAT + 1);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SEARCH = ST_SEARCH;
    localparam logic [1:0] S_WAIT   = ST_WAIT;
    localparam logic [1:0] S_MIX    = ST_MIX;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [12:0]   ptr;
    logic          first_tick;

    logic signed [8:0] a_s;
    logic signed [8:0] p_s;
    logic signed [7:0] mix_s;
    logic [7:0]        mix_out;

    assign tick      = (cnt == '0);
    assign search    = (state == S_SEARCH);
    assign offset    = ptr;
    assign state_dbg = state;

    // Free-running sample-period counter; count 0 is the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (cnt == CW'(SAMPLE_DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // Period FSM: SEARCH one cycle, WAIT READ_LAT-1 cycles, MIX one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick)
                        state <= S_SEARCH;
                end
                S_SEARCH: begin
                    wait_cnt <= '0;
                    if (READ_LAT == 1)
                        state <= S_MIX;
                    else
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WW'(READ_LAT - 2))
                        state <= S_MIX;
                    else
                        wait_cnt <= wait_cnt + WW'(1);
                end
                S_MIX:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Circular buffer pointer: advances on each tick except the first after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            first_tick <= 1'b1;
        end else if (tick) begin
            first_tick <= 1'b0;
            if (!first_tick) begin
                if (ptr == 13'(DEPTH - 1))
                    ptr <= '0;
                else
                    ptr <= ptr + 13'd1;
            end
        end
    end

    // Convert offset-binary samples to signed around silence.
    assign a_s = $signed({1'b0, audio_in} - 9'd128);
    assign p_s = $signed({1'b0, past_output} - 9'd128);

    team_06_echo_mixer #(
        .ECHO_SHIFT(ECHO_SHIFT)
    ) u_mixer (
        .a      (a_s),
        .p      (p_s),
        .enable (echo_enable),
        .s      (mix_s)
    );

    assign mix_out = $unsigned(mix_s) + SILENCE;

    // Output and write-back registers load once per period, in MIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_out   <= SILENCE;
            save_audio <= SILENCE;
        end else if (state == S_MIX) begin
            echo_out   <= mix_out;
            save_audio <= mix_out;
        end
    end

endmodule

// File: tb/tb_team_06_echo_effect.sv
// Directed bench for team_06_echo_effect (DEPTH=4, SAMPLE_DIV=8, READ_LAT=1).
module tb_team_06_echo_effect;

    logic        clk;
    logic        rst;
    logic [7:0]  audio_in;
    logic        echo_enable;
    logic [7:0]  past_output;
    logic [12:0] offset;
    logic        search;
    logic [7:0]  echo_out;
    logic [7:0]  save_audio;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_out;

    typedef struct {
        logic       en;
        logic [7:0] au;
        logic [7:0] pa;
        logic [7:0] ex;
    } vec_t;

    vec_t vecs[9];

    team_06_echo_effect #(
        .DEPTH(4), .SAMPLE_DIV(8), .READ_LAT(1), .ECHO_SHIFT(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .audio_in    (audio_in),
        .echo_enable (echo_enable),
        .past_output (past_output),
        .offset      (offset),
        .search      (search),
        .echo_out    (echo_out),
        .save_audio  (save_audio),
        .state_dbg   (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full sample period starting at a negedge just before the tick edge.
    task automatic run_period(input logic en0, input logic en1,
                              input logic [7:0] au, input logic [7:0] pa,
                              input logic [7:0] ex, input logic [12:0] off);
        logic [7:0] exp_v;
        echo_enable = en0;
        audio_in    = au;
        past_output = pa;
        exp_q.push_back(ex);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("search", int'(search), (c == 0) ? 1 : 0);
            if (c == 0 || c == 7)
                check("offset", int'(offset), int'(off));
            if (c < 2) begin
                check("echo_out_hold", int'(echo_out), int'(last_out));
                check("save_audio_hold", int'(save_audio), int'(last_out));
            end
            if (c == 1)
                echo_enable = en1;
            if (c == 2) begin
                exp_v = exp_q.pop_front();
                check("echo_out", int'(echo_out), int'(exp_v));
                check("save_audio", int'(save_audio), int'(exp_v));
                last_out = exp_v;
            end
            if (c == 7)
                check("echo_out_end", int'(echo_out), int'(last_out));
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd200, 8'd50,  8'd200};
        vecs[1] = '{1'b1, 8'd160, 8'd192, 8'd192};
        vecs[2] = '{1'b1, 8'd250, 8'd255, 8'd255};
        vecs[3] = '{1'b1, 8'd0,   8'd0,   8'd0};
        vecs[4] = '{1'b1, 8'd128, 8'd128, 8'd128};
        vecs[5] = '{1'b1, 8'd100, 8'd60,  8'd66};
        vecs[6] = '{1'b0, 8'd17,  8'd255, 8'd17};
        vecs[7] = '{1'b1, 8'd128, 8'd1,   8'd64};
        vecs[8] = '{1'b1, 8'd200, 8'd200, 8'd236};

        // Reset with random inputs
        rst = 1'b0;
        last_out = 8'd128;
        for (int i = 0; i < 4; i++) begin
            audio_in    = 8'($urandom_range(0, 255));
            past_output = 8'($urandom_range(0, 255));
            echo_enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_echo_out", int'(echo_out), 128);
            check("rst_save_audio", int'(save_audio), 128);
            check("rst_offset", int'(offset), 0);
            check("rst_search", int'(search), 0);
        end
        rst = 1'b1;

        // Table vectors; offsets 0,1,2,3,0,... cover the wrap
        for (int i = 0; i < 9; i++)
            run_period(vecs[i].en, vecs[i].en, vecs[i].au, vecs[i].pa,
                       vecs[i].ex, 13'(i % 4));

        // Enable toggled during MIX takes effect in the same period
        run_period(1'b0, 1'b1, 8'd160, 8'd192, 8'd192, 13'd1);

        // Reset asserted in the SEARCH cycle clears outputs without a clock edge
        echo_enable = 1'b1;
        audio_in    = 8'd160;
        past_output = 8'd192;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_search", int'(search), 1);
        check("pre_rst_offset", int'(offset), 2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_search", int'(search), 0);
        check("mid_rst_offset", int'(offset), 0);
        check("mid_rst_echo_out", int'(echo_out), 128);
        check("mid_rst_save_audio", int'(save_audio), 128);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_out = 8'd128;

        // First tick after release uses offset 0, then advances
        run_period(1'b1, 1'b1, 8'd160, 8'd192, 8'd192, 13'd0);
        run_period(1'b1, 1'b1, 8'd128, 8'd255, 8'd191, 13'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
